// File: rtl/score_pkg.sv
// score_pkg
// Shared constants, state encoding and the double-dabble step helper for the
// score binary-to-BCD reader. Imported by the converter, its interface and
// the seven-segment decoder.
// Optional build macro used elsewhere: SCORE_BCD_SEG_EN (segment outputs).
`timescale 1ns/1ps
package score_pkg;

  localparam int SCORE_W = 8;                        // binary score width
  localparam int DIGITS  = 3;                        // BCD digits, covers 255
  localparam int BCD_W   = 4;                        // bits per BCD digit
  localparam int ITER    = SCORE_W;                  // one iteration per score bit
  localparam int SREG_W  = DIGITS * BCD_W + SCORE_W; // {bcd digits, binary}

  localparam logic [6:0] SEG_BLANK = 7'b1111111;     // all segments off
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;     // digit 0, active-low gfedcba

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // One double-dabble iteration: every BCD nibble >= 5 gets +3 (4-bit add,
  // no carry into the next nibble; 5..9 becomes 8..12, so it never wraps),
  // then the whole register shifts left by one.
  function automatic logic [SREG_W-1:0] dabble_step(input logic [SREG_W-1:0] v);
    logic [SREG_W-1:0] a;
    a = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[SCORE_W + BCD_W*i +: BCD_W] >= 4'd5)
        a[SCORE_W + BCD_W*i +: BCD_W] = a[SCORE_W + BCD_W*i +: BCD_W] + 4'd3;
    end
    return {a[SREG_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/score_bcd_converter_if.sv
// score_bcd_converter_if
// Request/result bundle between the score counter side and the converter.
//   start  - single-cycle conversion request (sampled only when idle)
//   score  - binary score, captured on the accepting edge
//   busy   - conversion in progress
//   done   - one-cycle pulse when bcd takes a new value
//   bcd    - {hundreds, tens, ones}
//   hex2/hex1/hex0 - active-low segment patterns (only with SCORE_BCD_SEG_EN)
// Modports: master (requester side), slave (converter side).
`timescale 1ns/1ps
interface score_bcd_converter_if;
  import score_pkg::*;

  logic                      start;
  logic [SCORE_W-1:0]        score;
  logic                      busy;
  logic                      done;
  logic [DIGITS*BCD_W-1:0]   bcd;
`ifdef SCORE_BCD_SEG_EN
  logic [6:0]                hex2;
  logic [6:0]                hex1;
  logic [6:0]                hex0;
`endif

`ifdef SCORE_BCD_SEG_EN
  modport master (output start, output score,
                  input busy, input done, input bcd,
                  input hex2, input hex1, input hex0);
  modport slave  (input start, input score,
                  output busy, output done, output bcd,
                  output hex2, output hex1, output hex0);
`else
  modport master (output start, output score,
                  input busy, input done, input bcd);
  modport slave  (input start, input score,
                  output busy, output done, output bcd);
`endif

endinterface

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder
// Combinational BCD digit to active-low seven-segment pattern (gfedcba).
//   digit - 4-bit BCD code; 10..15 cannot occur from the converter and blank
//   seg   - active-low segments, bit 6 = g ... bit 0 = a
`timescale 1ns/1ps
module seven_seg_decoder
  import score_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_ZERO;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_bcd_converter.sv
// score_bcd_converter
// Sequential 8-bit binary to 3-digit BCD reader for the game score display.
// A start pulse in IDLE captures the score; eight shift-and-add-3 iterations
// follow, then bcd is loaded and done pulses for one cycle. bcd only ever
// changes on completion (or reset), so the display never sees partial digits.
// Ports:
//   clock   - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - score_bcd_converter_if.slave (start, score, busy, done, bcd, hex*)
// Build option: SCORE_BCD_SEG_EN adds registered hex2/hex1/hex0 segment
// outputs, updated one cycle after bcd.
//
// state | meaning
// IDLE  | waiting for start; bcd holds the last result
// SHIFT | double-dabble iterations in progress, busy=1
`timescale 1ns/1ps
module score_bcd_converter
  import score_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  score_bcd_converter_if.slave   bus
);

  state_t                  state;
  logic [SREG_W-1:0]       sreg;
  logic [SREG_W-1:0]       sreg_next;
  logic [3:0]              cnt;
  logic                    busy_q;
  logic                    done_q;
  logic [DIGITS*BCD_W-1:0] bcd_q;

  assign sreg_next = dabble_step(sreg);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sreg   <= {{(DIGITS*BCD_W){1'b0}}, bus.score};
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= sreg_next;
          cnt  <= cnt + 4'd1;
          // Last iteration: take the digits straight from this step's result
          // so bcd is valid on the same edge as the eighth shift.
          if (cnt == 4'(ITER - 1)) begin
            bcd_q  <= sreg_next[SREG_W-1 -: DIGITS*BCD_W];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

`ifdef SCORE_BCD_SEG_EN
  logic [6:0] seg2, seg1, seg0;
  logic [6:0] hex2_q, hex1_q, hex0_q;

  seven_seg_decoder u_dec2 (.digit(bcd_q[11:8]), .seg(seg2));
  seven_seg_decoder u_dec1 (.digit(bcd_q[7:4]),  .seg(seg1));
  seven_seg_decoder u_dec0 (.digit(bcd_q[3:0]),  .seg(seg0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hex2_q <= SEG_ZERO;
      hex1_q <= SEG_ZERO;
      hex0_q <= SEG_ZERO;
    end else begin
      hex2_q <= seg2;
      hex1_q <= seg1;
      hex0_q <= seg0;
    end
  end

  assign bus.hex2 = hex2_q;
  assign bus.hex1 = hex1_q;
  assign bus.hex0 = hex0_q;
`endif

endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter
// Directed bench for score_bcd_converter: reset state, single and
// back-to-back conversions, start-while-busy, mid-conversion reset, and a
// 0..255 sweep against a decimal reference. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_score_bcd_converter;
  import score_pkg::*;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;

  score_bcd_converter_if bus ();

  score_bcd_converter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] bcd_ref(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  // Call at a falling edge. Raises start for one cycle, then follows the
  // conversion to its done pulse (returns in the done cycle, at a falling edge).
  task automatic run_conv(input logic [7:0] s, input string tag);
    int lat;
    bus.score = s;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      @(negedge clock);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) n++;
    end
  endtask

  initial begin
    int n;
    int lat;
    logic ok;
    vectors     = 0;
    miscompares = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.score = '0;

    // Reset and idle
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst_bcd",  32'(bus.bcd),  32'h000);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
`ifdef SCORE_BCD_SEG_EN
    chk("rst_hex0", 32'(bus.hex0), 32'b1000000);
`endif

    // Max score
    run_conv(8'd255, "s255");
    chk("s255_bcd", 32'(bus.bcd), 32'h255);
    @(negedge clock);
    chk("s255_done_width", 32'(bus.done), 32'd0);
`ifdef SCORE_BCD_SEG_EN
    chk("s255_hex2", 32'(bus.hex2), 32'b0100100);
    chk("s255_hex1", 32'(bus.hex1), 32'b0010010);
    chk("s255_hex0", 32'(bus.hex0), 32'b0010010);
`endif

    // Back-to-back: each start is raised in the previous done cycle
    run_conv(8'd0, "b2b0");
    chk("b2b0_bcd", 32'(bus.bcd), 32'h000);
    run_conv(8'd99, "b2b99");
    chk("b2b99_bcd", 32'(bus.bcd), 32'h099);
    run_conv(8'd100, "b2b100");
    chk("b2b100_bcd", 32'(bus.bcd), 32'h100);
    @(negedge clock);

    // start re-asserted at E3 with a new score while converting 128
    bus.score = 8'd128;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bus.score = 8'd7;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    lat = 3;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk("busy_start_lat", 32'(lat), 32'd8);
    chk("busy_start_bcd", 32'(bus.bcd), 32'h128);
    count_dones(12, n);
    chk("busy_start_extra_done", 32'(n), 32'd0);

    // Reset at E4 of a conversion of 200
    bus.score = 8'd200;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_bcd",  32'(bus.bcd),  32'h000);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    count_dones(12, n);
    chk("mid_rst_no_done", 32'(n), 32'd0);
    chk("mid_rst_bcd_hold", 32'(bus.bcd), 32'h000);
    run_conv(8'd42, "after_rst");
    chk("after_rst_bcd", 32'(bus.bcd), 32'h042);
    @(negedge clock);

    // Full sweep
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), "sweep");
      chk($sformatf("sweep_bcd_%0d", v), 32'(bus.bcd), 32'(bcd_ref(v)));
      ok = (bus.bcd[11:8] <= 4'd9) && (bus.bcd[7:4] <= 4'd9) && (bus.bcd[3:0] <= 4'd9);
      chk($sformatf("sweep_nibbles_%0d", v), 32'(ok), 32'd1);
`ifdef SCORE_BCD_SEG_EN
      if (v == 137) begin
        @(negedge clock);
        chk("sweep_hex2", 32'(bus.hex2), 32'(seg_ref(1)));
        chk("sweep_hex1", 32'(bus.hex1), 32'(seg_ref(3)));
        chk("sweep_hex0", 32'(bus.hex0), 32'(seg_ref(7)));
      end
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
